// File: rtl/arb_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states and requester ids.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin pick; a tie goes to the port that did not win last.
module rr_arb2
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = P0;
    if (req0 && req1) gnt_id = ~last;
    else if (req1)    gnt_id = P1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM: grant, one RAM cycle,
// then a one-cycle ack with registered read data and an out-of-range error flag.
module ram_arbiter
  import arb_pkg::*;
#(
  parameter int depth = 128,
  parameter int bits  = 32,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [bits-1:0]  adr0,
  input  logic [width-1:0] din0,
  output logic             ack0,
  output logic             err0,
  output logic [width-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [bits-1:0]  adr1,
  input  logic [width-1:0] din1,
  output logic             ack1,
  output logic             err1,
  output logic [width-1:0] rdata1,
  output logic             ram_we,
  output logic [bits-1:0]  ram_adr,
  output logic [width-1:0] ram_din,
  input  logic [width-1:0] ram_dout
);

  // One extra bit so a depth equal to 2**bits still compares correctly.
  localparam logic [bits:0] DEPTH_X = (bits+1)'(depth);

  state_t             state, state_nx;
  logic               last;
  logic               gid;
  logic               cmd_we;
  logic [bits-1:0]    cmd_adr;
  logic [width-1:0]   cmd_din;
  logic               gnt_valid, gnt_id;
  logic               sel_we;
  logic [bits-1:0]    sel_adr;
  logic [width-1:0]   sel_din;
  logic               in_range;
  logic [width-1:0]   rd_val;

  rr_arb2 u_rr (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    sel_we  = we0;
    sel_adr = adr0;
    sel_din = din0;
    if (gnt_id == P1) begin
      sel_we  = we1;
      sel_adr = adr1;
      sel_din = din1;
    end
  end

  always_comb begin
    in_range = ({1'b0, cmd_adr} < DEPTH_X);
    rd_val   = in_range ? ram_dout : '0;
    ram_adr  = cmd_adr;
    ram_din  = cmd_din;
    ram_we   = (state == ACCESS) && cmd_we && in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_valid) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch and per-port response registers; the idle port's rdata is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= P1;
      gid     <= P0;
      cmd_we  <= 1'b0;
      cmd_adr <= '0;
      cmd_din <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gid     <= gnt_id;
            cmd_we  <= sel_we;
            cmd_adr <= sel_adr;
            cmd_din <= sel_din;
          end
        end
        ACCESS: begin
          if (gid == P0) begin
            rdata0 <= rd_val;
            err0   <= ~in_range;
            ack0   <= 1'b1;
          end else begin
            rdata1 <= rd_val;
            err1   <= ~in_range;
            ack1   <= 1'b1;
          end
        end
        RESP: begin
          last <= gid;
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err0 <= 1'b0;
          err1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data RAM (synchronous write, combinational read).
- It serialises accesses from requester 0 (CPU data port) and requester 1 (loader/debug port).
- It grants round-robin, drives the RAM's we/adr/din, and registers the read data per requester.
- Each access is completed with a one-cycle ack, plus an error flag for out-of-range addresses.

Parameters:
depth, 128, number of RAM words; addresses >= depth are out of range
bits, 32, address width
width, 32, data word width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request; held until ack0
we0  input  1  requester 0 write enable (1 = write, 0 = read)
adr0  input  bits  requester 0 word address
din0  input  width  requester 0 write data
ack0  output  1  one-cycle completion pulse for requester 0
err0  output  1  pulses with ack0 when the address was out of range
rdata0  output  width  registered read data for requester 0; valid from the ack0 cycle until its next ack
req1/we1/adr1/din1  input  1/1/bits/width  requester 1, same meaning as requester 0
ack1/err1/rdata1  output  1/1/width  requester 1, same meaning as requester 0
ram_we  output  1  RAM write enable
ram_adr  output  bits  RAM address
ram_din  output  width  RAM write data
ram_dout  input  width  RAM combinational read data

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, last = 1 (port 0 wins the first tie).
  - ack0/1 = 0, err0/1 = 0, rdata0/1 = 0.
  - Latched command registers = 0.
  - ram_we = 0, ram_adr = 0, ram_din = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last.
  - On the granting edge, latch gid, we, adr, din from the granted port and go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_adr = latched adr; ram_din = latched din.
  - ram_we = latched we AND in-range, where in-range means adr < depth (unsigned compare, full bits width).
  - At the edge: rdata[gid] <= in-range ? ram_dout : 0. A write returns the pre-write ram_dout, i.e. old contents.
  - err[gid] <= ~in-range; ack[gid] <= 1; go to RESP.
- RESP (one cycle):
  - ack[gid] = 1 and err[gid] valid.
  - At the edge: last <= gid, ack/err clear to 0, go to IDLE.
- Outside ACCESS, ram_we = 0 combinationally. ram_adr and ram_din hold their latched values.
- Latency: req sampled at edge k -> RAM write at edge k+1 -> ack high during cycle k+2. Throughput is one access per 3 cycles.
- Requester rules:
  - Requester must drop req in the ack cycle. If req is still high at the RESP->IDLE edge, it is a new request.
  - Changes to we/adr/din or req after the grant edge are ignored.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1... Neither port waits more than one other access.
- rdata of the non-granted port is never disturbed.
- Reset mid-operation:
  - Asynchronous clear; ram_we falls immediately and no write is committed.
  - The pending access is dropped with no ack; the requester re-requests.
- Out-of-range write: no RAM write, rdata = 0, err pulse with ack.
- Out-of-range read: rdata = 0, err pulse with ack.

Decomposition:
- Shared package (arb_pkg): state encoding constants IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2; port id constants P0 = 1'b0, P1 = 1'b1.
- Sub-module rr_arb2: combinational two-request round-robin pick. Inputs req0, req1, last; outputs gnt_valid, gnt_id.
- Remainder is FSM, latches and response registers in ram_arbiter. Bench instantiates ram_arbiter together with the existing RAM.

Test Plan:
- Reset then single write: req0 = 1, we0 = 1, adr0 = 5, din0 = 32'hDEADBEEF at edge 1.
  - Required: ram_we = 1 only in cycle 2, ack0 high in cycle 3, err0 = 0.
  - Then a read of adr0 = 5 returns rdata0 = 32'hDEADBEEF with ack0.
- Simultaneous requests: both ports read continuously after reset (adr0 = 1, adr1 = 2, preloaded 32'h11 and 32'h22).
  - Required: acks ordered 0,1,0,1 at 3-cycle spacing; rdata0 = 32'h11, rdata1 = 32'h22.
- Out of range: req1 write with adr1 = 128 (depth = 128), din1 = 32'hFFFF.
  - Required: ram_we stays 0, ack1 = 1 and err1 = 1 same cycle, rdata1 = 0.
  - A following read of word 0 is unchanged.
- Write returns old data: word 7 = 32'hA; port 0 writes 32'hB to word 7.
  - Required: rdata0 = 32'hA at ack0; next read returns 32'hB.
- Reset mid-op: assert rst during ACCESS of a write (din = 32'h55 to word 3, prior value 32'h0).
  - Required: ram_we drops immediately, no ack; word 3 remains 32'h0; port 0 wins the next tie.
- Late input change: after the grant edge, change adr0 from 4 to 9 while req0 is held.
  - Required: access hits word 4; holding req0 past ack0 starts a second access 1 cycle after RESP.
